// File: rtl/bram_tdp_param_if.sv
// One memory port: request fields driven by the client, read data and strobe returned by the RAM.
interface bram_tdp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic                  en;
  logic [DATA_W/8-1:0]   we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W-1:0]     dout;
  logic                  valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/bram_tdp_param.sv
// True dual-port RAM with byte enables, 1/2-cycle read latency, read-during-write mode,
// cross-port collision flag and a post-reset zeroing sweep.
module bram_tdp_param #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 1,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  bram_tdp_param_if.slave   port_a,
  bram_tdp_param_if.slave   port_b,
  output logic              o_busy,
  output logic              o_collision
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_next;
  logic                w_clr_we;
  logic                w_busy;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_acc   [2];
  logic [DATA_W-1:0]   w_old   [2];
  logic [DATA_W-1:0]   w_merge [2];
  logic [DATA_W-1:0]   w_rd    [2];
  logic [DATA_W-1:0]   w_dout  [2];
  logic                w_valid [2];
  logic                w_same_addr, w_any_wr;
  logic                r_collision;

  // Clear sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_clr_we        = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we        = 1'b1;
        w_clr_addr_next = r_clr_addr + 1'b1;
        if (&r_clr_addr) w_state_next = ST_IDLE;
      end
      default: ;
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);
  assign o_busy = w_busy;

  assign w_acc[0] = port_a.en & ~w_busy & ~rst;
  assign w_acc[1] = port_b.en & ~w_busy & ~rst;
  assign w_old[0] = r_mem[port_a.addr];
  assign w_old[1] = r_mem[port_b.addr];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign w_merge[0][gi*8 +: 8] = port_a.we[gi] ? port_a.din[gi*8 +: 8] : w_old[0][gi*8 +: 8];
      assign w_merge[1][gi*8 +: 8] = port_b.we[gi] ? port_b.din[gi*8 +: 8] : w_old[1][gi*8 +: 8];
    end
  endgenerate

  // Merged word equals the old word when this port does not write, so cross-port readers see old data.
  assign w_rd[0] = (RDW_MODE != 0) ? w_merge[0] : w_old[0];
  assign w_rd[1] = (RDW_MODE != 0) ? w_merge[1] : w_old[1];

  // Port A lanes are written last so they win on overlapping bytes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[r_clr_addr] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (w_acc[1] && port_b.we[i]) r_mem[port_b.addr][i*8 +: 8] <= port_b.din[i*8 +: 8];
          if (w_acc[0] && port_a.we[i]) r_mem[port_a.addr][i*8 +: 8] <= port_a.din[i*8 +: 8];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] r_rd1;
      logic              r_vld1;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd1  <= '0;
          r_vld1 <= 1'b0;
        end else begin
          r_vld1 <= w_acc[gi];
          if (w_acc[gi]) r_rd1 <= w_rd[gi];
        end
      end

      if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] r_rd2;
        logic              r_vld2;

        always_ff @(posedge clk) begin
          if (rst) begin
            r_rd2  <= '0;
            r_vld2 <= 1'b0;
          end else begin
            r_vld2 <= r_vld1;
            if (r_vld1) r_rd2 <= r_rd1;
          end
        end

        assign w_dout[gi]  = r_rd2;
        assign w_valid[gi] = r_vld2;
      end else begin : g_lat1
        assign w_dout[gi]  = r_rd1;
        assign w_valid[gi] = r_vld1;
      end
    end
  endgenerate

  assign port_a.dout  = w_dout[0];
  assign port_a.valid = w_valid[0];
  assign port_b.dout  = w_dout[1];
  assign port_b.valid = w_valid[1];

  assign w_same_addr = (port_a.addr == port_b.addr);
  assign w_any_wr    = (|port_a.we) | (|port_b.we);

  always_ff @(posedge clk) begin
    if (rst) r_collision <= 1'b0;
    else     r_collision <= w_acc[0] & w_acc[1] & w_same_addr & w_any_wr;
  end

  assign o_collision = r_collision;
endmodule

// File: doc/bram_tdp_param.md
Name: bram_tdp_param

Overview:
Parametrised true-dual-port block RAM, the successor to the fixed 8-bit x 1024 dual-port memory.
- Adds configurable width and depth, per-byte write enables, and selectable read latency (1 or 2) with a read-valid strobe.
- Adds a per-port read-during-write mode, cross-port collision detection, and a hardware clear sequencer that zeroes the array after reset.
- Serves as the shared sample/coefficient store between the datapath and the control/UART side.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8.
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
RD_LAT, 1, read latency in cycles; legal values 1 (array register only) or 2 (adds output register).
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
CLEAR_ON_RST, 1, 1 = sweep the whole array to zero after reset; 0 = no clear, contents retained.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
a_en  in  1  port A access request
a_we  in  DATA_W/8  port A byte write enables; bit i covers din[8i+7:8i]; all-zero = read
a_addr  in  ADDR_W  port A word address
a_din  in  DATA_W  port A write data
a_dout  out  DATA_W  port A read data
a_valid  out  1  port A read data valid strobe
b_en, b_we, b_addr, b_din, b_dout, b_valid  identical to port A, for port B
busy  out  1  clear sequence in progress; port requests are ignored while high
collision  out  1  one-cycle pulse flagging a same-address cross-port conflict

Behaviour:
- Reset (rst high):
  - a_dout, b_dout, a_valid, b_valid, collision = 0; all latency pipelines flushed.
  - Clear address counter = 0; busy = CLEAR_ON_RST. Array contents are not changed while rst is high.
- Clear FSM states: IDLE, CLEAR.
  - rst with CLEAR_ON_RST=1 -> CLEAR.
  - In CLEAR: one word per cycle is written with all zeros at the counter address, counter increments.
  - After address DEPTH-1 is written -> IDLE; busy drops on the following edge. busy is high for exactly DEPTH cycles after rst deasserts.
  - rst reasserted mid-clear: counter returns to 0 and the sweep restarts.
  - With CLEAR_ON_RST=0 the FSM stays in IDLE and busy is always 0.
- Request acceptance:
  - An access is accepted when x_en=1 and busy=0; requests while busy are dropped with no valid.
  - Write: applied to the bytes with x_we bit=1 at the edge of acceptance; other bytes keep their value.
  - Read data: every accepted access (read or write) returns x_dout with x_valid=1 exactly RD_LAT cycles after the accepting edge.
- Latency: RD_LAT=1 gives dout/valid on edge N+1; RD_LAT=2 on edge N+2.
  - Back-to-back requests each cycle give back-to-back valids, throughput 1 access per port per cycle.
  - x_dout holds its last value when x_valid=0.
- Same-port read-during-write:
  - RDW_MODE=0: dout = the word before the write.
  - RDW_MODE=1: dout = merged new word, i.e. written bytes new, unwritten bytes old.
- Cross-port, same address, both enabled:
  - Read on one port, write on the other: the reader gets old data regardless of RDW_MODE.
  - Both write: per byte, port A wins on any byte both enable; port B bytes not enabled by A are still written.
  - collision pulses 1 for one cycle, one edge after the accepting edge, whenever both ports are accepted at the same address and at least one writes. Two reads never flag.
- Different addresses: the ports are fully independent.
- Address width exactly covers DEPTH, so no out-of-range access exists.

Test Plan:
- Clear: DATA_W=8, ADDR_W=4, CLEAR_ON_RST=1; preload array nonzero via backdoor, pulse rst 1 cycle -> busy high 16 cycles then 0; reads of addresses 0..15 all return 0x00.
- Latency: RD_LAT=2; write 0xA5 to addr 3 on A; read addr 3 on B at edge N -> b_valid=1 and b_dout=0xA5 at edge N+2 only; b_valid is 0 at N+1.
- Byte enables: DATA_W=16; write 0x1234 with we=2'b11, then 0xABCD with we=2'b10 to addr 7 -> read returns 0xAB34.
- RDW: addr 5 holds 0x11; port A writes 0x22 with read at same edge -> RDW_MODE=0 returns 0x11, RDW_MODE=1 returns 0x22.
- Collision: A writes 0x0F and B writes 0xF0 to addr 9 at the same edge -> collision=1 for one cycle, word = 0x0F. A reads while B writes addr 9 -> collision=1 and a_dout = old value. Both read addr 9 -> collision stays 0.
- Mid-clear reset and busy gating: assert rst at clear counter 8 -> sweep restarts from 0 with busy for full DEPTH cycles. A write issued while busy has no effect and produces no a_valid.
